// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator-side controller between the pipeline MEM stage and DataMemory.
//   Accepts byte-addressed load/store requests on a valid/ready handshake,
//   issues word-addressed read/write strobes, extracts and extends sub-word
//   load data, and performs read-modify-write for byte/half stores because
//   DataMemory has no byte enables. Exactly one response per request.
//
// Ports
//   Clk, Reset_n          clock, synchronous active-low reset
//   Req_Valid/Req_Ready   request handshake
//   Req_Write             1 = store, 0 = load
//   Req_Size              00 byte, 01 half, 10 word, 11 illegal
//   Req_Unsigned          zero-extend loads when 1
//   Req_Addr              byte address
//   Req_Wdata             store data (sub-word data in the LSBs)
//   Resp_Valid/Resp_Ready response handshake
//   Resp_Data             extended load data, 0 for stores and errors
//   Resp_Error            misaligned address or illegal size
//   Address               word index to DataMemory (Req_Addr >> 2)
//   Write_Data            DataMemory write data
//   Sig_Mem_Write         DataMemory write strobe
//   Sig_Mem_Read          DataMemory read strobe
//   Read_Data             DataMemory read data
module load_store_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Write,
  input  logic [1:0]            Req_Size,
  input  logic                  Req_Unsigned,
  input  logic [ADDR_WIDTH-1:0] Req_Addr,
  input  logic [31:0]           Req_Wdata,
  output logic                  Resp_Valid,
  input  logic                  Resp_Ready,
  output logic [31:0]           Resp_Data,
  output logic                  Resp_Error,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [31:0]           Write_Data,
  output logic                  Sig_Mem_Write,
  output logic                  Sig_Mem_Read,
  input  logic [31:0]           Read_Data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [3:0] LAST_COUNT = 4'(MEM_LATENCY - 1);

  state_t      state_reg;
  logic        write_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [1:0]  lane_reg;
  logic [15:0] wdata_reg;
  logic [3:0]  count_reg;

  logic        misaligned;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Alignment/size check on the live request fields, used at acceptance.
  always_comb begin
    misaligned = 1'b0;
    case (Req_Size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = Req_Addr[0];
      2'b10:   misaligned = (Req_Addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Move the addressed lane down to bit 0; half lanes are always even so the
  // same byte shift covers both sizes.
  assign shifted = Read_Data >> {lane_reg, 3'b000};

  always_comb begin
    load_data = Read_Data;
    case (size_reg)
      2'b00: load_data = unsigned_reg ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_data = unsigned_reg ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = Read_Data;
    endcase
  end

  // Read-modify-write merge: each byte lane takes the new store data only if
  // the request covers it, otherwise it keeps the word just read back.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;
      assign hit = ((size_reg == 2'b00) && (lane_reg == LANE)) ||
                   ((size_reg == 2'b01) && (lane_reg[1] == LANE[1]));
      // A half store puts its low byte in the even lane, high byte in the odd.
      assign src = (size_reg == 2'b01 && LANE[0]) ? wdata_reg[15:8] : wdata_reg[7:0];
      assign merged[8*gi +: 8] = hit ? src : Read_Data[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      size_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
      lane_reg      <= 2'b00;
      wdata_reg     <= 16'd0;
      count_reg     <= 4'd0;
      Req_Ready     <= 1'b1;
      Resp_Valid    <= 1'b0;
      Resp_Data     <= 32'd0;
      Resp_Error    <= 1'b0;
      Address       <= '0;
      Write_Data    <= 32'd0;
      Sig_Mem_Write <= 1'b0;
      Sig_Mem_Read  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Req_Valid && Req_Ready) begin
            write_reg    <= Req_Write;
            size_reg     <= Req_Size;
            unsigned_reg <= Req_Unsigned;
            lane_reg     <= Req_Addr[1:0];
            wdata_reg    <= Req_Wdata[15:0];
            count_reg    <= 4'd0;
            Req_Ready    <= 1'b0;
            Address      <= Req_Addr >> 2;
            if (misaligned) begin
              state_reg  <= RESP;
              Resp_Valid <= 1'b1;
              Resp_Data  <= 32'd0;
              Resp_Error <= 1'b1;
            end else if (Req_Write && Req_Size == 2'b10) begin
              state_reg     <= WRITE;
              Write_Data    <= Req_Wdata;
              Sig_Mem_Write <= 1'b1;
            end else begin
              // Loads and sub-word stores both start by reading the word.
              state_reg    <= READ;
              Sig_Mem_Read <= 1'b1;
            end
          end
        end
        READ: begin
          if (count_reg == LAST_COUNT) begin
            Sig_Mem_Read <= 1'b0;
            if (write_reg) begin
              state_reg     <= WRITE;
              Write_Data    <= merged;
              Sig_Mem_Write <= 1'b1;
            end else begin
              state_reg  <= RESP;
              Resp_Valid <= 1'b1;
              Resp_Data  <= load_data;
              Resp_Error <= 1'b0;
            end
          end else begin
            count_reg <= count_reg + 4'd1;
          end
        end
        WRITE: begin
          state_reg     <= RESP;
          Sig_Mem_Write <= 1'b0;
          Resp_Valid    <= 1'b1;
          Resp_Data     <= 32'd0;
          Resp_Error    <= 1'b0;
        end
        RESP: begin
          if (Resp_Ready) begin
            state_reg  <= IDLE;
            Resp_Valid <= 1'b0;
            Resp_Data  <= 32'd0;
            Resp_Error <= 1'b0;
            Req_Ready  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a small DataMemory model.
//   Stimulus pushes expected responses into a scoreboard queue; a monitor
//   on the falling edge pops and compares on every response handshake and
//   also checks strobe counts, Address/Write_Data during strobes, latency
//   and response stability under backpressure.
module tb_load_store_unit;

  localparam int LAT = 1;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Write;
  logic [1:0]  Req_Size;
  logic        Req_Unsigned;
  logic [31:0] Req_Addr;
  logic [31:0] Req_Wdata;
  logic        Resp_Valid;
  logic        Resp_Ready;
  logic [31:0] Resp_Data;
  logic        Resp_Error;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic        Sig_Mem_Write;
  logic        Sig_Mem_Read;
  logic [31:0] Read_Data;

  load_store_unit #(.ADDR_WIDTH(32), .MEM_LATENCY(LAT)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
    .Req_Size(Req_Size), .Req_Unsigned(Req_Unsigned), .Req_Addr(Req_Addr),
    .Req_Wdata(Req_Wdata), .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
    .Resp_Data(Resp_Data), .Resp_Error(Resp_Error), .Address(Address),
    .Write_Data(Write_Data), .Sig_Mem_Write(Sig_Mem_Write),
    .Sig_Mem_Read(Sig_Mem_Read), .Read_Data(Read_Data)
  );

  always #5 Clk = ~Clk;

  // DataMemory model: combinational read, write on the rising edge.
  logic [31:0] mem [0:63];
  assign Read_Data = mem[Address[5:0]];
  always @(posedge Clk) if (Sig_Mem_Write) mem[Address[5:0]] <= Write_Data;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int          rd_cnt = 0, wr_cnt = 0;
  int          acc_cyc = 0, first_cyc = 0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
  logic [31:0] prev_data = 32'd0;

  always @(negedge Clk) begin
    if (Reset_n !== 1'b1) begin
      rd_cnt = 0;
      wr_cnt = 0;
      prev_valid = 1'b0;
    end else begin
      chk("strobe_overlap", 32'(Sig_Mem_Read && Sig_Mem_Write), 32'd0);
      if (Sig_Mem_Read) begin
        rd_cnt++;
        if (sb.size() != 0) chk("read_address", Address, sb[0].waddr);
      end
      if (Sig_Mem_Write) begin
        wr_cnt++;
        if (sb.size() != 0) begin
          chk("write_address", Address, sb[0].waddr);
          chk("write_data", Write_Data, sb[0].wdata);
        end
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(Resp_Valid), 32'd1);
        chk("hold_data", Resp_Data, prev_data);
        chk("hold_error", 32'(Resp_Error), 32'(prev_err));
      end
      if (Resp_Valid && !prev_valid) first_cyc = cyc;
      if (Resp_Valid && Resp_Ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_response: got data %h err %b required none", Resp_Data, Resp_Error);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_data", Resp_Data, e.data);
          chk("resp_error", 32'(Resp_Error), 32'(e.err));
          chk("latency", 32'(first_cyc - acc_cyc + 1), 32'(e.lat));
          chk("read_cycles", 32'(rd_cnt), 32'(e.nrd));
          chk("write_cycles", 32'(wr_cnt), 32'(e.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
      if (Req_Valid && Req_Ready) acc_cyc = cyc + 1;
      prev_valid = Resp_Valid;
      prev_ready = Resp_Ready;
      prev_data  = Resp_Data;
      prev_err   = Resp_Error;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (Req_Ready !== 1'b1 && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    if (Req_Ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got Req_Ready %b required 1", Req_Ready);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] edata, input logic eerr, input int lat,
                       input int nrd, input int nwr, input logic [31:0] ewd,
                       input logic do_drain);
    exp_t e;
    wait_ready();
    e.data = edata; e.err = eerr; e.lat = lat; e.nrd = nrd; e.nwr = nwr;
    e.waddr = addr >> 2; e.wdata = ewd;
    sb.push_back(e);
    Req_Valid = 1'b1; Req_Write = wr; Req_Size = sz; Req_Unsigned = uns;
    Req_Addr = addr; Req_Wdata = wd;
    @(posedge Clk); #1;
    Req_Valid = 1'b0;
    if (do_drain) drain();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    Reset_n = 1'b0; Req_Valid = 1'b1; Req_Write = 1'b0; Req_Size = 2'b10;
    Req_Unsigned = 1'b0; Req_Addr = 32'd12; Req_Wdata = 32'd0; Resp_Ready = 1'b1;

    // Reset held with a request pending: nothing may be accepted.
    repeat (2) begin
      @(posedge Clk); #1;
      chk("rst_req_ready", 32'(Req_Ready), 32'd1);
      chk("rst_resp_valid", 32'(Resp_Valid), 32'd0);
      chk("rst_strobes", 32'({Sig_Mem_Read, Sig_Mem_Write}), 32'd0);
    end
    Req_Valid = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("post_rst_idle", 32'(Resp_Valid), 32'd0);

    // Word store then word load.
    issue(1, 2'b10, 0, 32'd12, 32'd150, 32'd0, 0, 2, 0, 1, 32'd150, 1);
    issue(0, 2'b10, 0, 32'd12, 32'd0, 32'd150, 0, 2, 1, 0, 32'd0, 1);

    // Byte store RMW and byte loads.
    mem[3] = 32'h11223344;
    issue(1, 2'b00, 0, 32'd13, 32'h000000AA, 32'd0, 0, 3, 1, 1, 32'h1122AA44, 1);
    chk("mem_after_sb", mem[3], 32'h1122AA44);
    issue(0, 2'b00, 0, 32'd13, 32'd0, 32'hFFFFFFAA, 0, 2, 1, 0, 32'd0, 1);
    issue(0, 2'b00, 1, 32'd13, 32'd0, 32'h000000AA, 0, 2, 1, 0, 32'd0, 1);
    issue(0, 2'b10, 0, 32'd12, 32'd0, 32'h1122AA44, 0, 2, 1, 0, 32'd0, 1);

    // Half loads.
    mem[3] = 32'h80017FFF;
    issue(0, 2'b01, 0, 32'd14, 32'd0, 32'hFFFF8001, 0, 2, 1, 0, 32'd0, 1);
    issue(0, 2'b01, 1, 32'd14, 32'd0, 32'h00008001, 0, 2, 1, 0, 32'd0, 1);
    issue(0, 2'b01, 0, 32'd12, 32'd0, 32'h00007FFF, 0, 2, 1, 0, 32'd0, 1);

    // Error cases: no strobes, data 0, one-cycle latency.
    issue(0, 2'b01, 0, 32'd13, 32'd0, 32'd0, 1, 1, 0, 0, 32'd0, 1);
    issue(0, 2'b10, 0, 32'd2,  32'd0, 32'd0, 1, 1, 0, 0, 32'd0, 1);
    issue(0, 2'b11, 1, 32'd0,  32'd0, 32'd0, 1, 1, 0, 0, 32'd0, 1);
    issue(1, 2'b10, 0, 32'd13, 32'h5, 32'd0, 1, 1, 0, 0, 32'd0, 1);
    issue(1, 2'b01, 0, 32'd15, 32'h5, 32'd0, 1, 1, 0, 0, 32'd0, 1);
    chk("mem_after_errs", mem[3], 32'h80017FFF);

    // Half and byte stores into the upper lanes.
    issue(1, 2'b01, 0, 32'd14, 32'h1234BEEF, 32'd0, 0, 3, 1, 1, 32'hBEEF7FFF, 1);
    issue(1, 2'b00, 0, 32'd15, 32'h12345678, 32'd0, 0, 3, 1, 1, 32'h78EF7FFF, 1);
    issue(0, 2'b00, 0, 32'd12, 32'd0, 32'hFFFFFFFF, 0, 2, 1, 0, 32'd0, 1);
    issue(0, 2'b00, 1, 32'd14, 32'd0, 32'h000000EF, 0, 2, 1, 0, 32'd0, 1);

    // Backpressure: response held, new requests ignored.
    Resp_Ready = 1'b0;
    issue(0, 2'b10, 0, 32'd12, 32'd0, 32'h78EF7FFF, 0, 2, 1, 0, 32'd0, 0);
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'b10; Req_Addr = 32'd12; Req_Wdata = 32'hDEAD;
    repeat (5) begin
      @(posedge Clk); #1;
      chk("bp_req_ready", 32'(Req_Ready), 32'd0);
    end
    chk("bp_resp_valid", 32'(Resp_Valid), 32'd1);
    Req_Valid = 1'b0;
    Resp_Ready = 1'b1;
    drain();
    chk("bp_mem_unchanged", mem[3], 32'h78EF7FFF);

    // Address wraps with zero fill.
    issue(1, 2'b10, 0, 32'hFFFFFFFC, 32'hCAFEF00D, 32'd0, 0, 2, 0, 1, 32'hCAFEF00D, 1);
    issue(0, 2'b10, 0, 32'hFFFFFFFC, 32'd0, 32'hCAFEF00D, 0, 2, 1, 0, 32'd0, 1);

    // Reset during READ of a byte store: no write, no response.
    mem[5] = 32'h11223344;
    wait_ready();
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'b00; Req_Addr = 32'd21; Req_Wdata = 32'h99;
    @(posedge Clk); #1;
    Req_Valid = 1'b0;
    chk("abort_in_read", 32'(Sig_Mem_Read), 32'd1);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    chk("abort_ready", 32'(Req_Ready), 32'd1);
    repeat (4) begin
      chk("abort_no_write", 32'(Sig_Mem_Write), 32'd0);
      chk("abort_no_resp", 32'(Resp_Valid), 32'd0);
      @(posedge Clk); #1;
    end
    chk("abort_mem", mem[5], 32'h11223344);
    issue(0, 2'b10, 0, 32'd20, 32'd0, 32'h11223344, 0, 2, 1, 0, 32'd0, 1);

    repeat (3) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
